// File: rtl/accum_feeder_if.sv
// accum_feeder_if: producer-side valid/ready handshake carrying 32-bit sample words.
//   in_valid : producer offers in_data this cycle
//   in_ready : feeder can accept a word this cycle
//   in_data  : 32-bit sample word
// master = producer side, slave = feeder side.
interface accum_feeder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/accum_feeder.sv
// accum_feeder: buffers producer words in a small FIFO and replays each one to
// the accumulator as a one-cycle enable pulse, holding value stable for the
// accumulator's three-cycle capture sequence (PULSE, HOLD1, HOLD2), optionally
// followed by GAP idle cycles.
//   CLK     : clock, rising edge
//   RST_N   : asynchronous active-low reset
//   bus     : producer handshake (in_valid / in_ready / in_data), slave side
//   enable  : registered one-cycle issue pulse
//   value   : registered word to the accumulator, held between issues
//   level   : FIFO occupancy
//   busy    : issue sequence or gap in progress
//   issued  : count of issued words, wraps at 2^16
module accum_feeder #(
    parameter int DEPTH = 4,
    parameter int GAP   = 0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    accum_feeder_if.slave          bus,
    output logic                   enable,
    output logic [31:0]            value,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
    output logic [15:0]            issued
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);
    localparam logic [3:0]    GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PULSE = 3'd1;
    localparam logic [2:0] S_HOLD1 = 3'd2;
    localparam logic [2:0] S_HOLD2 = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   mem [DEPTH];
    logic [3:0]    gap_cnt;
    logic          push;
    logic          pop;
    logic          issue_slot;

    // Ready depends only on the registered level, so a pop in the same
    // cycle never opens a slot early.
    assign bus.in_ready = (level != FULL);
    assign push         = bus.in_valid && bus.in_ready;
    assign busy         = (state != S_IDLE);

    // issue_slot marks the cycles where the IDLE rule applies: pop the head
    // if the FIFO holds anything.
    always_comb begin
        issue_slot = 1'b0;
        case (state)
            S_IDLE:  issue_slot = 1'b1;
            S_HOLD2: issue_slot = (GAP == 0);
            S_GAP:   issue_slot = (gap_cnt == GAP_LAST);
            default: issue_slot = 1'b0;
        endcase
    end

    assign pop = issue_slot && (level != '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = pop ? S_PULSE : S_IDLE;
            S_PULSE: state_nxt = S_HOLD1;
            S_HOLD1: state_nxt = S_HOLD2;
            S_HOLD2: begin
                if (GAP > 0) state_nxt = S_GAP;
                else         state_nxt = pop ? S_PULSE : S_IDLE;
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = pop ? S_PULSE : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= S_IDLE;
            enable  <= 1'b0;
            value   <= '0;
            level   <= '0;
            issued  <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            gap_cnt <= '0;
        end else begin
            state  <= state_nxt;
            // enable is high exactly in the cycle following a pop, i.e. PULSE
            enable <= pop;
            if (pop) begin
                value  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
                issued <= issued + 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (state == S_HOLD2) begin
                gap_cnt <= '0;
            end else if (state == S_GAP && gap_cnt != GAP_LAST) begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    // Storage needs no reset: level gates every read.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

endmodule

// File: tb/tb_accum_feeder.sv
// tb_accum_feeder: directed table-driven bench for accum_feeder (DEPTH=4) with
// a GAP=0 instance for the main vectors and a GAP=2 instance for pacing.
module tb_accum_feeder;

    logic        CLK;
    logic        RST_N;

    logic        enable0;
    logic [31:0] value0;
    logic [2:0]  level0;
    logic        busy0;
    logic [15:0] issued0;

    logic        enable2;
    logic [31:0] value2;
    logic [2:0]  level2;
    logic        busy2;
    logic [15:0] issued2;

    int n_vec;
    int n_miss;

    accum_feeder_if bus0 ();
    accum_feeder_if bus2 ();

    accum_feeder #(.DEPTH(4), .GAP(0)) dut0 (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .bus    (bus0),
        .enable (enable0),
        .value  (value0),
        .level  (level0),
        .busy   (busy0),
        .issued (issued0)
    );

    accum_feeder #(.DEPTH(4), .GAP(2)) dut2 (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .bus    (bus2),
        .enable (enable2),
        .value  (value2),
        .level  (level2),
        .busy   (busy2),
        .issued (issued2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        valid;
        logic [31:0] data;
        logic        rdy;
        logic        en;
        logic [31:0] val;
        logic [2:0]  lvl;
        logic        busy;
        logic [15:0] iss;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic v, input logic [31:0] d,
                                input logic rdy, input logic en,
                                input logic [31:0] val, input logic [2:0] lvl,
                                input logic bsy, input logic [15:0] iss);
        vec_t t;
        t.valid = v;   t.data = d;   t.rdy = rdy; t.en = en;
        t.val   = val; t.lvl  = lvl; t.busy = bsy; t.iss = iss;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] A  = 32'h0001_0000;
    localparam logic [31:0] B  = 32'h0002_0000;
    localparam logic [31:0] C  = 32'h0003_0000;
    localparam logic [31:0] D  = 32'h0004_0000;
    localparam logic [31:0] W1 = 32'hA000_0001;
    localparam logic [31:0] W2 = 32'hA000_0002;
    localparam logic [31:0] W3 = 32'hA000_0003;
    localparam logic [31:0] W4 = 32'hA000_0004;
    localparam logic [31:0] W5 = 32'hA000_0005;
    localparam logic [31:0] W6 = 32'hA000_0006;
    localparam logic [31:0] W7 = 32'hA000_0007;
    localparam logic [31:0] W8 = 32'hA000_0008;

    initial begin
        logic [31:0] gw [3];
        int          pcyc [8];
        logic [31:0] pval [8];
        int          npulse;
        int          busy_low;
        int          stray_en;
        logic [53:0] got_v;
        logic [53:0] exp_v;

        n_vec  = 0;
        n_miss = 0;

        // ---- single word ----
        add(1, 32'd5, 1,0,32'd5*0,1,0,0);
        add(0, '0,    1,1,32'd5,0,1,1);
        add(0, '0,    1,0,32'd5,0,1,1);
        add(0, '0,    1,0,32'd5,0,1,1);
        add(0, '0,    1,0,32'd5,0,0,1);
        add(0, '0,    1,0,32'd5,0,0,1);
        // ---- burst, pulses 3 cycles apart ----
        add(1, A,  1,0,32'd5,1,0,1);
        add(1, B,  1,1,A,1,1,2);
        add(1, C,  1,0,A,2,1,2);
        add(1, D,  1,0,A,3,1,2);
        add(0, '0, 1,1,B,2,1,3);
        add(0, '0, 1,0,B,2,1,3);
        add(0, '0, 1,0,B,2,1,3);
        add(0, '0, 1,1,C,1,1,4);
        add(0, '0, 1,0,C,1,1,4);
        add(0, '0, 1,0,C,1,1,4);
        add(0, '0, 1,1,D,0,1,5);
        add(0, '0, 1,0,D,0,1,5);
        add(0, '0, 1,0,D,0,1,5);
        add(0, '0, 1,0,D,0,0,5);
        // ---- backpressure: valid held, word re-presented until accepted ----
        add(1, W1, 1,0,D, 1,0,5);
        add(1, W2, 1,1,W1,1,1,6);
        add(1, W3, 1,0,W1,2,1,6);
        add(1, W4, 1,0,W1,3,1,6);
        add(1, W5, 1,1,W2,3,1,7);
        add(1, W6, 0,0,W2,4,1,7);
        add(1, W7, 0,0,W2,4,1,7);
        add(1, W7, 1,1,W3,3,1,8);
        add(1, W7, 0,0,W3,4,1,8);
        add(1, W8, 0,0,W3,4,1,8);
        add(1, W8, 1,1,W4,3,1,9);
        add(1, W8, 0,0,W4,4,1,9);
        add(0, '0, 0,0,W4,4,1,9);
        add(0, '0, 1,1,W5,3,1,10);
        add(0, '0, 1,0,W5,3,1,10);
        add(0, '0, 1,0,W5,3,1,10);
        add(0, '0, 1,1,W6,2,1,11);
        add(0, '0, 1,0,W6,2,1,11);
        add(0, '0, 1,0,W6,2,1,11);
        add(0, '0, 1,1,W7,1,1,12);
        add(0, '0, 1,0,W7,1,1,12);
        add(0, '0, 1,0,W7,1,1,12);
        add(0, '0, 1,1,W8,0,1,13);
        add(0, '0, 1,0,W8,0,1,13);
        add(0, '0, 1,0,W8,0,1,13);
        add(0, '0, 1,0,W8,0,0,13);

        // ---- reset state ----
        RST_N         = 1'b0;
        bus0.in_valid = 1'b0;
        bus0.in_data  = '0;
        bus2.in_valid = 1'b0;
        bus2.in_data  = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_in_ready", 32'(bus0.in_ready), 32'd1);
        chk("reset_enable",   32'(enable0), 32'd0);
        chk("reset_value",    value0, 32'd0);
        chk("reset_level",    32'(level0), 32'd0);
        chk("reset_busy",     32'(busy0), 32'd0);
        chk("reset_issued",   32'(issued0), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // ---- table ----
        for (int i = 0; i < tbl.size(); i++) begin
            bus0.in_valid = tbl[i].valid;
            bus0.in_data  = tbl[i].data;
            @(posedge CLK);
            #1;
            got_v = {bus0.in_ready, enable0, value0, level0, busy0, issued0};
            exp_v = {tbl[i].rdy, tbl[i].en, tbl[i].val, tbl[i].lvl, tbl[i].busy, tbl[i].iss};
            n_vec++;
            if (got_v !== exp_v) begin
                n_miss++;
                $display("FAIL row%0d: got rdy=%b en=%b val=%h lvl=%0d busy=%b iss=%0d expected rdy=%b en=%b val=%h lvl=%0d busy=%b iss=%0d",
                         i, bus0.in_ready, enable0, value0, level0, busy0, issued0,
                         tbl[i].rdy, tbl[i].en, tbl[i].val, tbl[i].lvl, tbl[i].busy, tbl[i].iss);
            end
        end
        bus0.in_valid = 1'b0;

        // ---- reset during HOLD1 with two words buffered ----
        bus0.in_valid = 1'b1; bus0.in_data = 32'hC0DE_0001;
        @(posedge CLK); #1;
        bus0.in_data = 32'hC0DE_0002;
        @(posedge CLK); #1;
        bus0.in_data = 32'hC0DE_0003;
        @(posedge CLK); #1;
        bus0.in_valid = 1'b0;
        chk("hold1_level", 32'(level0), 32'd2);
        chk("hold1_value", value0, 32'hC0DE_0001);
        chk("hold1_busy",  32'(busy0), 32'd1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_rst_enable", 32'(enable0), 32'd0);
        chk("async_rst_value",  value0, 32'd0);
        chk("async_rst_level",  32'(level0), 32'd0);
        chk("async_rst_busy",   32'(busy0), 32'd0);
        chk("async_rst_issued", 32'(issued0), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        stray_en = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            if (enable0 || busy0) stray_en++;
        end
        chk("no_issue_after_reset", 32'(stray_en), 32'd0);
        chk("level_after_reset",    32'(level0), 32'd0);

        // ---- reset while enable is high ----
        bus0.in_valid = 1'b1; bus0.in_data = 32'h0BAD_F00D;
        @(posedge CLK); #1;
        bus0.in_valid = 1'b0;
        @(posedge CLK); #1;
        chk("pulse_enable", 32'(enable0), 32'd1);
        chk("pulse_value",  value0, 32'h0BAD_F00D);
        #2;
        RST_N = 1'b0;
        #1;
        chk("pulse_rst_enable", 32'(enable0), 32'd0);
        chk("pulse_rst_value",  value0, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // ---- GAP=2 pacing: pulses 5 cycles apart, busy held between ----
        gw[0] = 32'h0000_0111;
        gw[1] = 32'h0000_0222;
        gw[2] = 32'h0000_0333;
        npulse   = 0;
        busy_low = 0;
        for (int c = 0; c < 24; c++) begin
            bus2.in_valid = (c < 3);
            bus2.in_data  = (c < 3) ? gw[c] : '0;
            @(posedge CLK); #1;
            if (enable2) begin
                if (npulse < 8) begin
                    pcyc[npulse] = c;
                    pval[npulse] = value2;
                end
                npulse++;
            end
            if (c >= 1 && c <= 15 && !busy2) busy_low++;
        end
        bus2.in_valid = 1'b0;
        chk("gap_pulse_count", 32'(npulse), 32'd3);
        if (npulse >= 3) begin
            chk("gap_pulse0_cycle", 32'(pcyc[0]), 32'd1);
            chk("gap_pulse1_cycle", 32'(pcyc[1]), 32'd6);
            chk("gap_pulse2_cycle", 32'(pcyc[2]), 32'd11);
            chk("gap_pulse0_value", pval[0], gw[0]);
            chk("gap_pulse1_value", pval[1], gw[1]);
            chk("gap_pulse2_value", pval[2], gw[2]);
        end
        chk("gap_busy_held",   32'(busy_low), 32'd0);
        chk("gap_busy_final",  32'(busy2), 32'd0);
        chk("gap_issued",      32'(issued2), 32'd3);
        chk("gap_value_kept",  value2, gw[2]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/accum_feeder.md
# accum_feeder

Upstream feeder for the accumulator stage that drives the LED counter. Accepts 32-bit sample words from a producer over a valid/ready handshake and buffers them in a small FIFO. Replays each word to the accumulator as a one-cycle `enable` pulse plus a `value` held stable across the accumulator's three-cycle capture sequence. Pacing guarantees no `enable` is ever issued while the accumulator is mid-sequence.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `GAP`, 0: extra idle cycles inserted after each issue sequence; 0..15.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: producer offers `in_data`.
- `in_ready` out 1: feeder can accept a word this cycle.
- `in_data` in 32: sample word.
- `enable` out 1: registered one-cycle issue pulse to the accumulator.
- `value` out 32: registered word to the accumulator; held between issues.
- `level` out log2(DEPTH)+1: current FIFO occupancy.
- `busy` out 1: high while an issue sequence or gap is in progress.
- `issued` out 16: count of words issued; wraps 0xFFFF→0.

## Operation
- Push: word written at the rising edge where `in_valid && in_ready`. `in_ready = (level != DEPTH)`, computed from current state only. A pop in the same cycle does not open a slot early.
- FIFO: circular buffer with read/write pointers of log2(DEPTH) bits, wrapping modulo DEPTH. `level` is tracked separately, so full and empty are unambiguous.
- FSM states:
  - IDLE: if `level != 0`, pop head, load `value`, go to PULSE. Otherwise stay.
  - PULSE: `enable`=1. Next state HOLD1.
  - HOLD1: next state HOLD2.
  - HOLD2: accumulator captures `value` at the end of this cycle. Next state is GAP if `GAP>0`, else the same rule as IDLE (pop and go to PULSE if non-empty, else IDLE).
  - GAP: counts `GAP` cycles, then applies the IDLE rule.
- `enable` is registered and high only in PULSE.
- `value` changes only on entry to PULSE and holds through PULSE, HOLD1 and HOLD2. After that it keeps the last issued word.
- `busy` = state ≠ IDLE.
- `issued` increments by 1, modulo 2^16, on each entry to PULSE.
- Simultaneous push and pop: `level` is unchanged. Both pointers advance.
- Push when empty while in IDLE: the word is not bypassed. It is popped the following cycle.

## Timing
- Reset values (asynchronous, while `RST_N`=0): state IDLE, `enable`=0, `value`=0, `level`=0, `busy`=0, `issued`=0, pointers 0. `in_ready`=1 immediately after reset.
- Reset mid-operation: all buffered words and any in-flight sequence are discarded. `enable` drops asynchronously.
- Latency: word accepted at edge t0 into an empty FIFO while IDLE → `enable` high during the cycle after edge t0+1.
- Throughput: one issue per 3+GAP cycles. Consecutive `enable` pulses are spaced exactly 3+GAP cycles apart while the FIFO is non-empty.
- Capture window: `value` is stable from the rising edge that asserts `enable` through the edge ending HOLD2, which covers 3 edges.

## Test plan
- Single word: reset, push 0x0000_0005 → `enable` high for exactly one cycle, two edges after acceptance. `value`=5 for ≥3 cycles. `issued`=1. Downstream accumulator count becomes 5.
- Burst: push 0x10000, 0x20000, 0x30000, 0x40000 back-to-back, GAP=0 → four `enable` pulses 3 cycles apart. Values issued in order. Downstream `led` reaches 0x0A.
- Backpressure: DEPTH=4, push 6 words continuously → `in_ready`=0 when `level`=4. The 5th word is accepted only after a pop. No word is lost or duplicated. Pointers wrap correctly.
- Gap: GAP=2, push 3 words → `enable` pulses 5 cycles apart. `busy` stays high between them.
- Reset mid-burst: drop `RST_N` during HOLD1 with `level`=2 → `enable`=0, `value`=0, `level`=0 asynchronously. After release, no `enable` until a new push.
- Counter wrap: preload or issue 65536 words → `issued` returns to 0. Issue cadence is unaffected.
